uart_tx_unit: RTL and testbench

UART_TX_UNIT -- requirements
Module: uart_tx_unit

---
 rtl/uart_tx_unit_pkg.sv | 18 +
 rtl/uart_tx_unit_baud_rate_generator.sv | 29 ++
 rtl/uart_tx_unit.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_unit_pkg.sv
// Shared constants and FSM state encoding for the UART transmit unit.
package uart_tx_unit_pkg;

    localparam int DEF_DBITS    = 8;
    localparam int DEF_SB_TICKS = 16;
    localparam int DEF_BR_LIMIT = 651;
    localparam int DEF_BR_BITS  = 10;
    localparam int DEF_FIFO_EXP = 2;
    localparam int OVERSAMPLE   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_unit_baud_rate_generator.sv
// Free-running baud counter; tick is high for one clock every BR_LIMIT clocks.
module baud_rate_generator
    import uart_tx_unit_pkg::*;
#(
    parameter int BR_LIMIT = DEF_BR_LIMIT,
    parameter int BR_BITS  = DEF_BR_BITS
) (
    input  logic clk_100MHz,
    input  logic reset,
    output logic tick
);

    localparam logic [BR_BITS-1:0] COUNT_LAST = BR_BITS'(BR_LIMIT - 1);

    logic [BR_BITS-1:0] r_count;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == COUNT_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == COUNT_LAST);

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: small TX FIFO feeding a 16x-oversampled serializer.
// state | meaning
// IDLE  | line high, pop head of FIFO when not empty
// START | start bit (low) for 16 ticks
// DATA  | DBITS data bits, LSB first, 16 ticks each
// STOP  | stop bit (high) for SB_TICKS ticks, then done pulse
module uart_tx_unit
    import uart_tx_unit_pkg::*;
#(
    parameter int DBITS    = DEF_DBITS,
    parameter int SB_TICKS = DEF_SB_TICKS,
    parameter int BR_LIMIT = DEF_BR_LIMIT,
    parameter int BR_BITS  = DEF_BR_BITS,
    parameter int FIFO_EXP = DEF_FIFO_EXP
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             write_uart,
    input  logic [DBITS-1:0] write_data,
    output logic             tx,
    output logic             tx_full,
    output logic             tx_empty,
    output logic             tx_done_tick
);

    localparam int DEPTH = 1 << FIFO_EXP;
    localparam int S_W   = $clog2((SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE);
    localparam int N_W   = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBITS - 1);

    logic                w_tick;
    logic [DBITS-1:0]    r_mem [DEPTH];
    logic [FIFO_EXP-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_inc, w_rd_ptr_inc;
    logic                r_full, r_empty, w_wr_en, w_pop;
    tx_state_t           r_state, w_state_next;
    logic [S_W-1:0]      r_s, w_s_next;
    logic [N_W-1:0]      r_n, w_n_next;
    logic [DBITS-1:0]    r_shift, w_shift_next;
    logic                r_tx, w_tx_next, r_done, w_done_next;

    baud_rate_generator #(
        .BR_LIMIT (BR_LIMIT),
        .BR_BITS  (BR_BITS)
    ) u_baud (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick       (w_tick)
    );

    assign w_wr_en      = write_uart & ~r_full;
    assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    always_ff @(posedge clk_100MHz) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    // Flags only move when exactly one of write/pop happens.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_en) r_wr_ptr <= w_wr_ptr_inc;
            if (w_pop)   r_rd_ptr <= w_rd_ptr_inc;
            if (w_wr_en && !w_pop) begin
                r_empty <= 1'b0;
                r_full  <= (w_wr_ptr_inc == r_rd_ptr);
            end else if (w_pop && !w_wr_en) begin
                r_full  <= 1'b0;
                r_empty <= (w_rd_ptr_inc == r_wr_ptr);
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_done_next  = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_s_next     = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = ST_DATA;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next     = '0;
                        w_shift_next = r_shift >> 1;
                        w_n_next     = r_n + 1'b1;
                        if (r_n == N_LAST) begin
                            w_state_next = ST_STOP;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Line level is registered from the next state so it lines up with r_state.
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign tx_full      = r_full;
    assign tx_empty     = r_empty;
    assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit with a frame-schedule reference model.
module tb_uart_tx_unit;

    localparam int DBITS    = 8;
    localparam int SB_TICKS = 16;
    localparam int BR_LIMIT = 4;
    localparam int BR_BITS  = 10;
    localparam int FIFO_EXP = 2;
    localparam int DEPTH    = 4;
    localparam int BIT_CYC  = 16 * BR_LIMIT;
    localparam int MAXW     = 8192;
    localparam int TXB = 3, DNB = 2, FLB = 1, EMB = 0;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic       write_uart = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       tx, tx_full, tx_empty, tx_done_tick;

    int checks = 0;
    int errors = 0;
    int n_frames;

    bit         wr_en  [MAXW];
    logic [7:0] wr_dat [MAXW];
    logic [3:0] exp_w  [MAXW];
    logic [3:0] obs_w  [MAXW];

    always #5 clk_100MHz = ~clk_100MHz;

    uart_tx_unit #(
        .DBITS    (DBITS),
        .SB_TICKS (SB_TICKS),
        .BR_LIMIT (BR_LIMIT),
        .BR_BITS  (BR_BITS),
        .FIFO_EXP (FIFO_EXP)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .write_uart   (write_uart),
        .write_data   (write_data),
        .tx           (tx),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .tx_done_tick (tx_done_tick)
    );

    task automatic clear_sched();
        for (int k = 0; k < MAXW; k++) begin
            wr_en[k]  = 1'b0;
            wr_dat[k] = 8'h00;
        end
    endtask

    // Leaves the bench 1 ns into cycle 0, the first cycle with reset low.
    task automatic do_reset();
        @(posedge clk_100MHz);
        #1 reset = 1'b1;
        write_uart = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        #1 reset = 1'b0;
    endtask

    task automatic run_window(input int len);
        for (int k = 0; k < len; k++) begin
            write_uart = wr_en[k];
            write_data = wr_dat[k];
            @(negedge clk_100MHz);
            obs_w[k] = {tx, tx_done_tick, tx_full, tx_empty};
            @(posedge clk_100MHz);
            #1;
        end
        write_uart = 1'b0;
    endtask

    // Frame schedule: flags lag the queue by one cycle, a pop in cycle k puts the
    // start bit on the line at k+1, the start bit ends on the 16th baud tick
    // (ticks in cycles where k mod BR_LIMIT == BR_LIMIT-1), then 8 data bits and
    // one stop bit of BIT_CYC each; done pulses in the first idle cycle.
    task automatic build_model(input int len);
        logic [7:0] q[$];
        logic [7:0] b;
        int free_at, sz, c0, t1, e, idx;
        free_at  = 0;
        n_frames = 0;
        for (int k = 0; k < len; k++) exp_w[k] = 4'b1000;
        for (int k = 0; k < len; k++) begin
            sz = q.size();
            exp_w[k][FLB] = (sz == DEPTH);
            exp_w[k][EMB] = (sz == 0);
            if (k >= free_at && sz > 0) begin
                b  = q.pop_front();
                c0 = k + 1;
                t1 = c0;
                while ((t1 % BR_LIMIT) != BR_LIMIT - 1) t1++;
                e = t1 + 15 * BR_LIMIT + 1;
                for (int c = c0; c < e && c < len; c++) exp_w[c][TXB] = 1'b0;
                for (int i = 0; i < DBITS; i++)
                    for (int j = 0; j < BIT_CYC; j++) begin
                        idx = e + i * BIT_CYC + j;
                        if (idx < len) exp_w[idx][TXB] = b[i];
                    end
                free_at = e + (DBITS + 1) * BIT_CYC;
                if (free_at < len) exp_w[free_at][DNB] = 1'b1;
                n_frames++;
            end
            if (wr_en[k] && sz < DEPTH) q.push_back(wr_dat[k]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        checks++;
        if ({tx, tx_done_tick, tx_full, tx_empty} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_state got tx/done/full/empty %b%b%b%b want 1001",
                     tx, tx_done_tick, tx_full, tx_empty);
        end
    endtask

    task automatic test_idle();
        int bad, nd;
        clear_sched();
        do_reset();
        build_model(1000);
        run_window(1000);
        bad = -1; nd = 0;
        for (int k = 0; k < 1000; k++) begin
            if (obs_w[k] !== exp_w[k] && bad < 0) bad = k;
            if (obs_w[k][DNB] === 1'b1) nd++;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL idle_wave cycle %0d got %b want %b", bad, obs_w[bad], exp_w[bad]);
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL idle_done got %0d pulses want 0", nd);
        end
    endtask

    task automatic test_single();
        int bad, nd, hi;
        logic [7:0] got;
        clear_sched();
        wr_en[0] = 1'b1; wr_dat[0] = 8'h26;
        do_reset();
        build_model(700);
        run_window(700);
        bad = -1; nd = 0;
        for (int k = 0; k < 700; k++) begin
            if (obs_w[k] !== exp_w[k] && bad < 0) bad = k;
            if (obs_w[k][DNB] === 1'b1) nd++;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL single_wave cycle %0d got %b want %b", bad, obs_w[bad], exp_w[bad]);
        end
        checks++;
        if ({obs_w[1][TXB], obs_w[2][TXB]} !== 2'b10) begin
            errors++;
            $display("FAIL single_latency got tx c1/c2 %b%b want 10", obs_w[1][TXB], obs_w[2][TXB]);
        end
        for (int i = 0; i < 8; i++) got[i] = obs_w[64 + i * BIT_CYC + 32][TXB];
        checks++;
        if (got !== 8'h26) begin
            errors++;
            $display("FAIL single_bits got %h want 26", got);
        end
        hi = 0;
        for (int k = 576; k < 640; k++) if (obs_w[k][TXB] === 1'b1) hi++;
        checks++;
        if (hi !== 64) begin
            errors++;
            $display("FAIL single_stop got %0d high cycles want 64", hi);
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL single_done got %0d pulses want 1", nd);
        end
    endtask

    task automatic test_burst();
        int bad, nd;
        logic [7:0] got, want;
        clear_sched();
        for (int k = 0; k < 6; k++) begin
            wr_en[k]  = 1'b1;
            wr_dat[k] = 8'(8'h41 + k);
        end
        do_reset();
        build_model(3300);
        run_window(3300);
        bad = -1; nd = 0;
        for (int k = 0; k < 3300; k++) begin
            if (obs_w[k] !== exp_w[k] && bad < 0) bad = k;
            if (obs_w[k][DNB] === 1'b1) nd++;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL burst_wave cycle %0d got %b want %b", bad, obs_w[bad], exp_w[bad]);
        end
        checks++;
        if ({obs_w[4][FLB], obs_w[5][FLB]} !== 2'b01) begin
            errors++;
            $display("FAIL burst_full got full c4/c5 %b%b want 01", obs_w[4][FLB], obs_w[5][FLB]);
        end
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 8; i++) got[i] = obs_w[64 + 640 * j + i * BIT_CYC + 32][TXB];
            want = 8'(8'h41 + j);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL burst_byte%0d got %h want %h", j, got, want);
            end
        end
        checks++;
        if (nd !== 5) begin
            errors++;
            $display("FAIL burst_done got %0d pulses want 5", nd);
        end
        checks++;
        if (obs_w[3299][EMB] !== 1'b1) begin
            errors++;
            $display("FAIL burst_empty got %b want 1", obs_w[3299][EMB]);
        end
    endtask

    task automatic test_simul();
        int bad, nd;
        clear_sched();
        wr_en[0] = 1'b1; wr_dat[0] = 8'h3C;
        wr_en[1] = 1'b1; wr_dat[1] = 8'hC3;
        do_reset();
        build_model(1300);
        run_window(1300);
        bad = -1; nd = 0;
        for (int k = 0; k < 1300; k++) begin
            if (obs_w[k] !== exp_w[k] && bad < 0) bad = k;
            if (obs_w[k][DNB] === 1'b1) nd++;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL simul_wave cycle %0d got %b want %b", bad, obs_w[bad], exp_w[bad]);
        end
        checks++;
        if ({obs_w[2][FLB], obs_w[2][EMB]} !== 2'b00) begin
            errors++;
            $display("FAIL simul_occupancy got full/empty %b%b want 00", obs_w[2][FLB], obs_w[2][EMB]);
        end
        checks++;
        if ({obs_w[640][TXB], obs_w[641][TXB]} !== 2'b10) begin
            errors++;
            $display("FAIL simul_restart got tx c640/c641 %b%b want 10", obs_w[640][TXB], obs_w[641][TXB]);
        end
        checks++;
        if (nd !== 2) begin
            errors++;
            $display("FAIL simul_done got %0d pulses want 2", nd);
        end
    endtask

    task automatic test_reset_mid();
        int bad, nd;
        clear_sched();
        wr_en[0] = 1'b1; wr_dat[0] = 8'h55;
        wr_en[1] = 1'b1; wr_dat[1] = 8'hA1;
        wr_en[2] = 1'b1; wr_dat[2] = 8'hB2;
        do_reset();
        build_model(280);
        run_window(280);
        @(negedge clk_100MHz);
        checks++;
        if ({tx, tx_empty} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_pre got tx/empty %b%b want 00", tx, tx_empty);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tx, tx_empty, tx_full, tx_done_tick} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_async got tx/empty/full/done %b%b%b%b want 1100",
                     tx, tx_empty, tx_full, tx_done_tick);
        end
        repeat (2) @(posedge clk_100MHz);
        #1 reset = 1'b0;
        clear_sched();
        build_model(1000);
        run_window(1000);
        bad = -1; nd = 0;
        for (int k = 0; k < 1000; k++) begin
            if (obs_w[k] !== exp_w[k] && bad < 0) bad = k;
            if (obs_w[k][DNB] === 1'b1) nd++;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL rstmid_after cycle %0d got %b want %b", bad, obs_w[bad], exp_w[bad]);
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL rstmid_done got %0d pulses want 0", nd);
        end
    endtask

    task automatic test_random(input int iter);
        int bad, nd, nw, c;
        clear_sched();
        nw = int'($urandom_range(6, 10));
        for (int i = 0; i < nw; i++) begin
            c = int'($urandom_range(0, 1200));
            wr_en[c]  = 1'b1;
            wr_dat[c] = 8'($urandom);
        end
        do_reset();
        build_model(7700);
        run_window(7700);
        bad = -1; nd = 0;
        for (int k = 0; k < 7700; k++) begin
            if (obs_w[k] !== exp_w[k] && bad < 0) bad = k;
            if (obs_w[k][DNB] === 1'b1) nd++;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL random%0d_wave cycle %0d got %b want %b", iter, bad, obs_w[bad], exp_w[bad]);
        end
        checks++;
        if (nd !== n_frames) begin
            errors++;
            $display("FAIL random%0d_done got %0d pulses want %0d", iter, nd, n_frames);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_burst();
        test_simul();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
